// File: rtl/crc_pkg.sv
// crc_pkg
// Shared definitions for the streaming CRC engine:
//   - crc_state_e : frame-level state of the engine (IDLE / ACCUM / HOLD)
//   - polynomial presets in normal (MSB-first) form for common CRCs
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // register holds INIT, no beat of the frame seen yet
    ST_ACCUM = 2'd1,  // mid-frame, at least one non-last beat folded
    ST_HOLD  = 2'd2   // result presented, waiting for out_ready
  } crc_state_e;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step
// Purely combinational single-byte CRC update: crc_out = step(crc_in, data_in).
// The register is kept in normal (MSB-first) form; REFIN only changes the
// order in which the eight data bits are shifted in.
// Ports:
//   crc_in  [CRC_W-1:0]  register value before this byte
//   data_in [7:0]        byte to fold in
//   crc_out [CRC_W-1:0]  register value after this byte
module crc_byte_step #(
  parameter int              CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(8'h07),
  parameter bit              REFIN = 1'b0
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] crc_work;
  logic             feedback;

  always_comb begin
    crc_work = crc_in;
    feedback = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // Reflected input consumes the byte LSB-first, otherwise MSB-first.
      feedback = crc_work[CRC_W-1] ^ (REFIN ? data_in[i] : data_in[7-i]);
      crc_work = (crc_work << 1) ^ ({CRC_W{feedback}} & POLY);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine
// Streaming CRC generator: accepts one DATA_W-bit beat per clock on a
// valid/ready input, folds all byte lanes (lane 0 first) into the CRC
// register, and presents the finished CRC on a valid/ready output one cycle
// after the last beat is accepted.
// Ports:
//   clock, reset          clock (rising edge) and asynchronous active-high reset
//   clear                 synchronous frame abort, highest priority
//   in_valid/in_ready     input beat handshake (in_ready is a registered state decode)
//   in_data [DATA_W-1:0]  beat payload, lane 0 = bits [7:0]
//   in_keep [DATA_W/8-1:0] lane enables, only looked at on the last beat
//   in_last               final beat of frame
//   out_valid/out_ready   result handshake
//   out_crc [CRC_W-1:0]   final CRC after optional reflection and XOROUT
//   out_err               last-beat keep was not contiguous from lane 0
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0,
  parameter logic [CRC_W-1:0] XOROUT = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W/8-1:0]   in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CRC_W-1:0]      out_crc,
  output logic                  out_err
);

  localparam int LANES = DATA_W / 8;

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] out_crc_q, out_crc_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  // chain[n] = register after folding lanes 0..n-1 of the current beat.
  logic [CRC_W-1:0] chain [0:LANES];

  assign chain[0] = crc_q;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [CRC_W-1:0] crc_i;
      logic [CRC_W-1:0] crc_o;
      if (gi == 0) begin : g_first
        assign crc_i = crc_q;
      end else begin : g_next
        assign crc_i = g_lane[gi-1].crc_o;
      end
      crc_byte_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .REFIN (REFIN)
      ) u_step (
        .crc_in  (crc_i),
        .data_in (in_data[8*gi +: 8]),
        .crc_out (crc_o)
      );
      assign chain[gi+1] = crc_o;
    end
  endgenerate

  // Last-beat keep analysis: keep_len is the number of lanes before the
  // first cleared keep bit; keep_gap flags a set bit beyond that hole.
  int   keep_len;
  logic keep_hole;
  logic keep_gap;

  always_comb begin
    keep_len  = LANES;
    keep_hole = 1'b0;
    keep_gap  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!in_keep[i]) begin
        if (!keep_hole) keep_len = i;
        keep_hole = 1'b1;
      end else if (keep_hole) begin
        keep_gap = 1'b1;
      end
    end
  end

  // Register value after this beat: whole beat unless it is the last one,
  // in which case only the contiguous kept prefix counts.
  logic [CRC_W-1:0] fold_crc;

  always_comb begin
    fold_crc = chain[LANES];
    if (in_last) begin
      for (int i = 0; i <= LANES; i++) begin
        if (keep_len == i) fold_crc = chain[i];
      end
    end
  end

  logic [CRC_W-1:0] fold_rev;
  logic [CRC_W-1:0] final_crc;

  generate
    for (genvar gi = 0; gi < CRC_W; gi++) begin : g_rev
      assign fold_rev[gi] = fold_crc[CRC_W-1-gi];
    end
  endgenerate

  assign final_crc = (REFOUT ? fold_rev : fold_crc) ^ XOROUT;

  logic accept;
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    out_crc_d = out_crc_q;
    out_err_d = out_err_q;

    if (clear) begin
      state_d   = ST_IDLE;
      crc_d     = INIT;
      out_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            if (in_last) begin
              state_d   = ST_HOLD;
              crc_d     = fold_crc;
              out_crc_d = final_crc;
              out_err_d = keep_gap;
            end else begin
              state_d = ST_ACCUM;
              crc_d   = chain[LANES];
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d   = ST_IDLE;
            crc_d     = INIT;
            out_err_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          crc_d   = INIT;
        end
      endcase
    end

    // Both handshake flags are decoded from the next state so they are
    // plain flops on the ports.
    out_valid_d = (state_d == ST_HOLD);
    in_ready_d  = (state_d != ST_HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      out_crc_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      out_crc_q   <= out_crc_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine
// Directed bench with three engine configurations sharing clock and reset:
//   A: CRC-8 (poly 07), 8-bit beats
//   B: CRC-16/CCITT-FALSE (poly 1021, init FFFF), 32-bit beats
//   C: CRC-32 (reflected, init/xorout FFFFFFFF), 64-bit beats
// Expected values are the published check values of "123456789".
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_clear, a_ivalid, a_irdy, a_last, a_ovalid, a_ordy, a_err;
  logic [7:0] a_data;
  logic [0:0] a_keep;
  logic [7:0] a_crc;

  logic        b_clear, b_ivalid, b_irdy, b_last, b_ovalid, b_ordy, b_err;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic [15:0] b_crc;

  logic        c_clear, c_ivalid, c_irdy, c_last, c_ovalid, c_ordy, c_err;
  logic [63:0] c_data;
  logic [7:0]  c_keep;
  logic [31:0] c_crc;

  crc_stream_engine #(
    .CRC_W(8), .DATA_W(8)
  ) u_a (
    .clock(clk), .reset(rst), .clear(a_clear),
    .in_valid(a_ivalid), .in_ready(a_irdy), .in_data(a_data), .in_keep(a_keep),
    .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_ordy),
    .out_crc(a_crc), .out_err(a_err)
  );

  crc_stream_engine #(
    .CRC_W(16), .DATA_W(32), .POLY(CRC16_CCITT_POLY), .INIT(16'hFFFF)
  ) u_b (
    .clock(clk), .reset(rst), .clear(b_clear),
    .in_valid(b_ivalid), .in_ready(b_irdy), .in_data(b_data), .in_keep(b_keep),
    .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_ordy),
    .out_crc(b_crc), .out_err(b_err)
  );

  crc_stream_engine #(
    .CRC_W(32), .DATA_W(64), .POLY(CRC32_POLY), .INIT(32'hFFFFFFFF),
    .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF)
  ) u_c (
    .clock(clk), .reset(rst), .clear(c_clear),
    .in_valid(c_ivalid), .in_ready(c_irdy), .in_data(c_data), .in_keep(c_keep),
    .in_last(c_last), .out_valid(c_ovalid), .out_ready(c_ordy),
    .out_crc(c_crc), .out_err(c_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic get_irdy(input int sel);
    case (sel)
      0:       return a_irdy;
      1:       return b_irdy;
      default: return c_irdy;
    endcase
  endfunction

  function automatic logic get_ovalid(input int sel);
    case (sel)
      0:       return a_ovalid;
      1:       return b_ovalid;
      default: return c_ovalid;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      0:       return a_err;
      1:       return b_err;
      default: return c_err;
    endcase
  endfunction

  function automatic logic [31:0] get_crc(input int sel);
    case (sel)
      0:       return 32'(a_crc);
      1:       return 32'(b_crc);
      default: return c_crc;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [63:0] data, input logic [7:0] keep,
                       input logic last, input logic valid);
    case (sel)
      0: begin a_ivalid = valid; a_data = data[7:0];  a_keep = keep[0:0]; a_last = last; end
      1: begin b_ivalid = valid; b_data = data[31:0]; b_keep = keep[3:0]; b_last = last; end
      default: begin c_ivalid = valid; c_data = data; c_keep = keep; c_last = last; end
    endcase
  endtask

  task automatic idle(input int sel);
    drive(sel, 64'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic set_ordy(input int sel, input logic v);
    case (sel)
      0:       a_ordy = v;
      1:       b_ordy = v;
      default: c_ordy = v;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic beat(input int sel, input logic [63:0] data, input logic [7:0] keep,
                      input logic last, output int acc_cyc);
    int  n;
    bit  rdy;
    n = 0;
    acc_cyc = -1;
    drive(sel, data, keep, last, 1'b1);
    forever begin
      rdy = get_irdy(sel);
      @(posedge clk);
      if (rdy) begin
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
      n++;
      if (n > 40) begin
        expect_eq("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_msg(input int sel, input int lanes, output int first_cyc);
    string       s;
    logic [63:0] d;
    logic [7:0]  k;
    int          c;
    s = "123456789";
    first_cyc = -1;
    for (int b = 0; b < 9; b += lanes) begin
      d = '0;
      k = '0;
      for (int l = 0; l < lanes; l++) begin
        if (b + l < 9) begin
          d[8*l +: 8] = s[b+l];
          k[l] = 1'b1;
        end
      end
      beat(sel, d, k, (b + lanes >= 9), c);
      if (b == 0) first_cyc = c;
    end
  endtask

  // Called at the falling edge right after the last beat was accepted.
  task automatic take_result(input int sel, input string tag, input logic [31:0] exp_crc,
                             input logic exp_err);
    expect_eq({tag, " valid"}, 32'(get_ovalid(sel)), 32'd1);
    expect_eq({tag, " crc"}, get_crc(sel), exp_crc);
    expect_eq({tag, " err"}, 32'(get_err(sel)), 32'(exp_err));
    idle(sel);
    set_ordy(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(sel, 1'b0);
    expect_eq({tag, " drop"}, 32'(get_ovalid(sel)), 32'd0);
    expect_eq({tag, " rdy"}, 32'(get_irdy(sel)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    rst = 1'b1;
    a_clear = 0; b_clear = 0; c_clear = 0;
    a_ordy = 0; b_ordy = 0; c_ordy = 0;
    for (int s = 0; s < 3; s++) idle(s);

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      expect_eq($sformatf("rst%0d irdy", s), 32'(get_irdy(s)), 32'd0);
      expect_eq($sformatf("rst%0d ovalid", s), 32'(get_ovalid(s)), 32'd0);
      expect_eq($sformatf("rst%0d crc", s), get_crc(s), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++)
      expect_eq($sformatf("post_rst%0d irdy", s), 32'(get_irdy(s)), 32'd1);

    // Single byte 0x68, result must be up one cycle after acceptance.
    beat(0, 64'h68, 8'h01, 1'b1, c0);
    take_result(0, "crc8 68", 32'h1F, 1'b0);

    // Check value through a 9-beat frame.
    send_msg(0, 1, c0);
    take_result(0, "crc8 msg", 32'hF4, 1'b0);

    // CRC-16 in three 32-bit beats, last keep 0001.
    send_msg(1, 4, c0);
    take_result(1, "crc16 msg", 32'h29B1, 1'b0);

    // One-beat frame with empty keep gives the INIT-derived value.
    beat(1, 64'hDEADBEEF, 8'h00, 1'b1, c0);
    take_result(1, "crc16 keep0", 32'hFFFF, 1'b0);

    // Non-contiguous keep 0101: only lane 0 ("9") is folded, error raised.
    beat(1, 64'h34333231, 8'h0F, 1'b0, c0);
    beat(1, 64'h38373635, 8'h0F, 1'b0, c0);
    beat(1, 64'h00AA5539, 8'h05, 1'b1, c0);
    take_result(1, "crc16 holes", 32'h29B1, 1'b1);

    // Clear mid-frame together with a last beat: beat ignored, frame dropped.
    beat(1, 64'h34333231, 8'h0F, 1'b0, c0);
    drive(1, 64'h39393939, 8'h0F, 1'b1, 1'b1);
    b_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_clear = 1'b0;
    idle(1);
    expect_eq("clear ovalid", 32'(b_ovalid), 32'd0);
    expect_eq("clear irdy", 32'(b_irdy), 32'd1);
    send_msg(1, 4, c0);
    take_result(1, "crc16 after clear", 32'h29B1, 1'b0);

    // Clear while a result is held.
    beat(1, 64'h0, 8'h00, 1'b1, c0);
    idle(1);
    b_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_clear = 1'b0;
    expect_eq("clear hold ovalid", 32'(b_ovalid), 32'd0);
    expect_eq("clear hold irdy", 32'(b_irdy), 32'd1);

    // Reset mid-frame discards the partial CRC.
    beat(1, 64'h34333231, 8'h0F, 1'b0, c0);
    idle(1);
    rst = 1'b1;
    #1;
    expect_eq("async rst irdy", 32'(b_irdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("rst release irdy", 32'(b_irdy), 32'd1);
    send_msg(1, 4, c0);
    take_result(1, "crc16 after rst", 32'h29B1, 1'b0);

    // CRC-32 with a 5-cycle output stall.
    send_msg(2, 8, c0);
    for (int i = 0; i < 5; i++) begin
      expect_eq($sformatf("crc32 stall%0d crc", i), c_crc, 32'hCBF43926);
      expect_eq($sformatf("crc32 stall%0d irdy", i), 32'(c_irdy), 32'd0);
      if (i == 4) break;
      @(negedge clk);
    end
    take_result(2, "crc32 msg", 32'hCBF43926, 1'b0);

    // Back-to-back frames with out_ready tied high.
    a_ordy = 1'b1;
    send_msg(0, 1, c0);
    expect_eq("b2b f0 crc", 32'(a_ovalid ? a_crc : 8'h00), 32'hF4);
    send_msg(0, 1, c1);
    expect_eq("b2b f1 crc", 32'(a_ovalid ? a_crc : 8'h00), 32'hF4);
    expect_eq("b2b 9beat period", 32'(c1 - c0), 32'd10);
    beat(0, 64'h68, 8'h01, 1'b1, c0);
    expect_eq("b2b s0 crc", 32'(a_ovalid ? a_crc : 8'h00), 32'h1F);
    beat(0, 64'h68, 8'h01, 1'b1, c1);
    expect_eq("b2b s1 crc", 32'(a_ovalid ? a_crc : 8'h00), 32'h1F);
    beat(0, 64'h68, 8'h01, 1'b1, c2);
    expect_eq("b2b s2 crc", 32'(a_ovalid ? a_crc : 8'h00), 32'h1F);
    expect_eq("b2b 1beat period a", 32'(c1 - c0), 32'd2);
    expect_eq("b2b 1beat period b", 32'(c2 - c1), 32'd2);
    idle(0);
    @(negedge clk);
    a_ordy = 1'b0;
    expect_eq("b2b end ovalid", 32'(a_ovalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
